unified_mem_ctrl: RTL and testbench
===================================

UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8: byte-address width.
REQ-003 SHALL have parameter DEPTH, default 64: number of words in internal RAM, at most 2^(ADDR_W-log2(DATA_W/8)).
REQ-004 SHALL have parameter WAIT, default 1: extra access cycles, range 0-15.
REQ-005 SHALL define BE_W = DATA_W/8 and OFS = log2(BE_W).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1) is the clock, rising-edge; reset (input, 1) is the async reset, active-low.
REQ-007 SHALL have i_req (input, 1): instruction fetch request.
REQ-008 SHALL have i_addr (input, ADDR_W): fetch byte address.
REQ-009 SHALL have i_ready (output, 1): one-cycle fetch completion pulse.
REQ-010 SHALL have i_rdata (output, DATA_W): fetched word.
REQ-011 SHALL have d_req (input, 1): data request.
REQ-012 SHALL have d_we (input, 1): 1 = write, 0 = read.
REQ-013 SHALL have d_be (input, BE_W): write byte enables; bit k covers byte lane k.
REQ-014 SHALL have d_addr (input, ADDR_W): data byte address.
REQ-015 SHALL have d_wdata (input, DATA_W): write data.
REQ-016 SHALL have d_ready (output, 1): one-cycle data completion pulse.
REQ-017 SHALL have d_rdata (output, DATA_W): read word.
REQ-018 SHALL have busy (output, 1): high whenever the FSM is not in IDLE.
REQ-019 SHALL have err (output, 1): sticky out-of-range flag.

Function
REQ-020 SHALL hold a single-port RAM of DEPTH x DATA_W, shared by both ports; word index = addr[ADDR_W-1:OFS], with addr[OFS-1:0] ignored.
REQ-021 SHALL use a three-state FSM (IDLE, BUSY, RESP): IDLE goes to BUSY when a request is sampled and loads wait counter = WAIT; BUSY decrements the counter and, at the edge where it is 0, performs the access and goes to RESP; RESP lasts one cycle and returns to IDLE.
REQ-022 SHALL assert the ready of the granted port for exactly the RESP cycle, so a request first sampled at edge E gets ready high in the cycle after edge E+WAIT+1.
REQ-023 SHALL require the requester to hold req, address, we, be and wdata stable until ready; values are latched at grant, and changes after grant are ignored.
REQ-024 SHALL, when only one port requests in IDLE, grant that port.
REQ-025 SHALL, when both ports request in the same IDLE cycle, grant the port not granted last (round-robin); after reset, last_grant = D, so the first contended grant goes to I.
REQ-026 SHALL keep the ungranted request pending, with no ready, until it wins a later IDLE cycle.
REQ-027 SHALL, on a read, load the addressed word into the port's rdata register at the access edge; the other port's rdata is unchanged.
REQ-028 SHALL, on a write, update only the byte lanes with d_be[k]=1 at the access edge; d_be=0 still completes the handshake with no RAM change; d_rdata is unchanged on writes.
REQ-029 SHALL treat a word index >= DEPTH as out-of-range: reads return 0, writes are discarded, the handshake completes normally, and err is set to 1 at the access edge.
REQ-030 SHALL, when req is low in IDLE, take no action; a req deasserted before grant is not serviced.
REQ-031 SHALL give a minimum spacing of WAIT+3 cycles between consecutive grants; ready and a new grant never coincide.

Reset
REQ-032 SHALL, on reset low, immediately force state=IDLE, counter=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, err=0, busy=0, last_grant=D.
REQ-033 SHALL, on reset asserted mid-access, abort the access: no ready pulse, and a write whose access edge has not yet occurred leaves the RAM unmodified.
REQ-034 SHALL NOT clear RAM contents on reset; they are undefined after power-up.
REQ-035 SHALL, after reset release, sample requests starting from the first rising edge.

Verification
REQ-036 SHALL be verified with WAIT=1: D write addr 0x04, be=4'b1111, wdata 0xDEADBEEF -> d_ready pulses 3 cycles after req; then I read addr 0x04 -> i_rdata=0xDEADBEEF with the i_ready pulse.
REQ-037 SHALL be verified with byte enables: write 0x11223344 to 0x08, then write be=4'b0010, wdata 0x0000AA00 -> D read 0x08 returns 0x1122AA44.
REQ-038 SHALL be verified under contention: i_req and d_req rise in the same cycle after reset -> I is served first, D follows with a ready pulse WAIT+3 cycles after I's; repeated contention alternates D, I.
REQ-039 SHALL be verified for out-of-range with DEPTH=32: read addr 0xFC -> d_rdata=0, err=1 and stays 1; write 0xFC -> RAM words 0-31 unchanged.
REQ-040 SHALL be verified for reset mid-access: reset low during BUSY of a write to 0x10 -> no d_ready, busy=0, and a subsequent read of 0x10 returns the old value.
REQ-041 SHALL be verified with WAIT=0: a single read has ready in the cycle after edge E+1, and the busy width is 2 cycles.

Source files
------------

// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_ctrl
//  Purpose  : Single-port word RAM shared by an instruction-fetch port and a
//             data port. Round-robin arbitration, a programmable number of
//             wait cycles per access, byte-enabled writes and a sticky
//             out-of-range error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module unified_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    parameter int WAIT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    // Instruction fetch port
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ready,
    output logic [DATA_W-1:0]     i_rdata,

    // Data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     d_rdata,

    // Status
    output logic                  busy,
    output logic                  err
);

    localparam int BE_W   = DATA_W / 8;
    localparam int OFS    = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int IDX_W  = ADDR_W - OFS;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0]       C_WAIT  = 4'(WAIT);
    localparam logic [IDX_W:0]   C_DEPTH = (IDX_W + 1)'(DEPTH);

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_e              state_q,   state_d;
    logic [3:0]          cnt_q,     cnt_d;
    logic                gnt_q,     gnt_d;
    logic                last_q,    last_d;
    logic                we_q,      we_d;
    logic [BE_W-1:0]     be_q,      be_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                err_q,     err_d;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                w_access;
    logic                w_in_range;
    logic [MEM_AW-1:0]   w_word;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_wr_en;
    logic                w_pick_d;

    // The access edge is the last BUSY edge, once the wait counter has drained.
    assign w_access   = (state_q == S_BUSY) && (cnt_q == 4'd0);
    assign w_in_range = ({1'b0, idx_q} < C_DEPTH);
    assign w_word     = idx_q[MEM_AW-1:0];
    assign w_rd_word  = w_in_range ? mem[w_word] : '0;
    assign w_wr_en    = w_access && we_q && w_in_range;

    // Data port wins if it is alone, or if both request and I was granted last.
    assign w_pick_d   = d_req && (!i_req || (last_q == GNT_I));

    // Byte-offset address bits select nothing inside a word; they are dropped.
    generate
        if (OFS > 0) begin : g_ofs_bits
            logic w_unused_ofs;
            assign w_unused_ofs = ^{i_addr[OFS-1:0], d_addr[OFS-1:0]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic: arbitration, wait counting and the access itself
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        we_d      = we_q;
        be_d      = be_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_d = S_BUSY;
                    cnt_d   = C_WAIT;
                    gnt_d   = w_pick_d;
                    last_d  = w_pick_d;
                    if (w_pick_d) begin
                        we_d    = d_we;
                        be_d    = d_be;
                        idx_d   = d_addr[ADDR_W-1:OFS];
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        be_d    = '0;
                        idx_d   = i_addr[ADDR_W-1:OFS];
                        wdata_d = '0;
                    end
                end
            end

            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    if (!w_in_range) begin
                        err_d = 1'b1;
                    end
                    if (!we_q) begin
                        if (gnt_q == GNT_D) begin
                            d_rdata_d = w_rd_word;
                        end else begin
                            i_rdata_d = w_rd_word;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register; reset aborts any access in flight
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            gnt_q     <= GNT_I;
            last_q    <= GNT_D;
            we_q      <= 1'b0;
            be_q      <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            we_q      <= we_d;
            be_q      <= be_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM write port: byte lanes gated by the latched enables; not reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_q[k]) begin
                    mem[w_word][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign i_ready = (state_q == S_RESP) && (gnt_q == GNT_I);
    assign d_ready = (state_q == S_RESP) && (gnt_q == GNT_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unified_mem_ctrl
//  Purpose  : Scoreboard bench for unified_mem_ctrl. A word-level reference
//             model predicts each response when a request is issued; an
//             independent monitor pops and compares on every ready pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 32;
    localparam int WT    = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (WAIT=1, DEPTH=32)
    logic          i_req, i_ready;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_ready;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          busy, err;

    // Second DUT (WAIT=0) for the zero-wait latency case
    logic          z_i_req, z_i_ready;
    logic [AW-1:0] z_i_addr;
    logic [DW-1:0] z_i_rdata;
    logic          z_d_req, z_d_we, z_d_ready;
    logic [3:0]    z_d_be;
    logic [AW-1:0] z_d_addr;
    logic [DW-1:0] z_d_wdata, z_d_rdata;
    logic          z_busy, z_err;

    unified_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(WT)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .busy(busy), .err(err)
    );

    unified_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .i_req(z_i_req), .i_addr(z_i_addr), .i_ready(z_i_ready), .i_rdata(z_i_rdata),
        .d_req(z_d_req), .d_we(z_d_we), .d_be(z_d_be), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
        .d_ready(z_d_ready), .d_rdata(z_d_rdata), .busy(z_busy), .err(z_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        bit          exp_err;
        int          exp_cyc;
    } resp_t;

    resp_t sb[$];

    // Reference model state
    logic [31:0] m_mem [0:63];
    bit          m_err;
    logic [31:0] m_i, m_d;
    bit          m_last_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply one access to the model and queue the response it must produce.
    function automatic void model_op(input bit is_d, input bit we, input logic [3:0] be,
                                     input logic [7:0] addr, input logic [31:0] wd, input int exp_cyc);
        int          idx = int'(addr) / 4;
        bit          inr = (idx < DEPTH);
        logic [31:0] mask;
        resp_t       r;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (!inr) m_err = 1'b1;
        if (is_d && we) begin
            if (inr) m_mem[idx] = (m_mem[idx] & ~mask) | (wd & mask);
        end else if (is_d) begin
            m_d = inr ? m_mem[idx] : 32'h0;
        end else begin
            m_i = inr ? m_mem[idx] : 32'h0;
        end
        m_last_d  = is_d;
        r.is_d    = is_d;
        r.exp_i   = m_i;
        r.exp_d   = m_d;
        r.exp_err = m_err;
        r.exp_cyc = exp_cyc;
        sb.push_back(r);
    endfunction

    // Monitor: compare every ready pulse against the oldest expectation.
    initial begin : mon
        resp_t r;
        forever begin
            @(negedge clk);
            if (reset && (i_ready || d_ready)) begin
                if (i_ready && d_ready) begin
                    checks++; errors++;
                    $display("FAIL dual_ready: both readies high at cycle %0d", cyc);
                end
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: i_ready %0b d_ready %0b with nothing expected at cycle %0d",
                             i_ready, d_ready, cyc);
                end else begin
                    r = sb.pop_front();
                    chk("ready_port", {31'b0, d_ready}, {31'b0, r.is_d});
                    chk("ready_cycle", 32'(cyc), 32'(r.exp_cyc));
                    chk("i_rdata", i_rdata, r.exp_i);
                    chk("d_rdata", d_rdata, r.exp_d);
                    chk("err", {31'b0, err}, {31'b0, r.exp_err});
                    chk("busy_in_resp", {31'b0, busy}, 32'd1);
                end
            end
        end
    end

    // One round: issue I and/or D together, hold until each ready, then idle.
    task automatic round(input bit do_i, input bit do_d, input logic [7:0] ia, input bit dwe,
                         input logic [3:0] dbe, input logic [7:0] da, input logic [31:0] dwd);
        int c = cyc;
        int n = 0;
        if (do_i && do_d) begin
            if (!m_last_d) begin
                model_op(1'b1, dwe, dbe, da, dwd, c + WT + 2);
                model_op(1'b0, 1'b0, 4'h0, ia, 32'h0, c + 2*WT + 5);
            end else begin
                model_op(1'b0, 1'b0, 4'h0, ia, 32'h0, c + WT + 2);
                model_op(1'b1, dwe, dbe, da, dwd, c + 2*WT + 5);
            end
        end else if (do_i) begin
            model_op(1'b0, 1'b0, 4'h0, ia, 32'h0, c + WT + 2);
        end else if (do_d) begin
            model_op(1'b1, dwe, dbe, da, dwd, c + WT + 2);
        end
        i_req = do_i; i_addr = ia;
        d_req = do_d; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
        while ((i_req || d_req) && n < 4*WT + 20) begin
            @(negedge clk);
            n++;
            if (i_ready) i_req = 1'b0;
            if (d_ready) d_req = 1'b0;
        end
        if (i_req || d_req) begin
            checks++; errors++;
            $display("FAIL round_timeout: i_req %0b d_req %0b still pending after %0d cycles", i_req, d_req, n);
            i_req = 1'b0; d_req = 1'b0;
            sb.delete();
        end
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 8'($urandom_range(128, 255));
        return 8'($urandom_range(0, 127));
    endfunction

    // Zero-wait instance: one data access, checking latency and busy width.
    task automatic w0_op(input bit we, input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        int c  = cyc;
        int rc = -1;
        int bw = 0;
        z_d_req = 1'b1; z_d_we = we; z_d_be = 4'hF; z_d_addr = a; z_d_wdata = wd;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (z_busy) bw++;
            if (z_d_ready && rc < 0) begin
                rc = cyc;
                z_d_req = 1'b0;
            end
        end
        z_d_req = 1'b0;
        chk("w0_ready_cycle", 32'(rc), 32'(c + 2));
        chk("w0_busy_width", 32'(bw), 32'd2);
        if (!we) chk("w0_rdata", z_d_rdata, exp_rd);
    endtask

    initial begin
        logic [31:0] old_val;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        z_i_req = 0; z_i_addr = 0; z_d_req = 0; z_d_we = 0; z_d_be = 0; z_d_addr = 0; z_d_wdata = 0;
        m_err = 0; m_i = 0; m_d = 0; m_last_d = 1;

        // Reset values while reset is held low
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_i_ready", {31'b0, i_ready}, 32'd0);
        chk("rst_d_ready", {31'b0, d_ready}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Give every in-range word a known value
        for (int w = 0; w < DEPTH; w++) round(1'b0, 1'b1, 8'h0, 1'b1, 4'hF, 8'(w * 4), $urandom);

        // Full-word write then fetch
        round(1'b0, 1'b1, 8'h0, 1'b1, 4'hF, 8'h04, 32'hDEADBEEF);
        round(1'b1, 1'b0, 8'h04, 1'b0, 4'h0, 8'h0, 32'h0);
        chk("fetch_deadbeef", i_rdata, 32'hDEADBEEF);

        // Byte-lane merge
        round(1'b0, 1'b1, 8'h0, 1'b1, 4'hF, 8'h08, 32'h11223344);
        round(1'b0, 1'b1, 8'h0, 1'b1, 4'b0010, 8'h08, 32'h0000AA00);
        round(1'b0, 1'b1, 8'h0, 1'b0, 4'h0, 8'h0A, 32'h0);
        chk("be_merge", d_rdata, 32'h1122AA44);

        // Zero byte enables: handshake only
        round(1'b0, 1'b1, 8'h0, 1'b1, 4'h0, 8'h08, 32'hFFFFFFFF);

        // Out-of-range read and write
        round(1'b0, 1'b1, 8'h0, 1'b0, 4'h0, 8'hFC, 32'h0);
        chk("oor_rdata", d_rdata, 32'h0);
        chk("oor_err", {31'b0, err}, 32'd1);
        round(1'b0, 1'b1, 8'h0, 1'b1, 4'hF, 8'hFC, 32'h5A5A5A5A);
        chk("oor_err_sticky", {31'b0, err}, 32'd1);

        // Reset while a write to 0x10 is waiting
        old_val = m_mem[4];
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 8'h10; d_wdata = ~old_val;
        @(negedge clk);
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b0; d_req = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_err", {31'b0, err}, 32'd0);
        chk("abort_d_rdata", d_rdata, 32'h0);
        m_err = 0; m_i = 0; m_d = 0; m_last_d = 1;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_ready", {31'b0, d_ready}, 32'd0);
        end
        round(1'b0, 1'b1, 8'h0, 1'b0, 4'h0, 8'h10, 32'h0);
        chk("abort_old_value", d_rdata, old_val);

        // Contention right after reset, then repeated contention
        for (int k = 0; k < 4; k++)
            round(1'b1, 1'b1, rand_addr(), 1'($urandom), 4'($urandom), rand_addr(), $urandom);

        // Randomised traffic
        for (int k = 0; k < 200; k++) begin
            int mode = $urandom_range(0, 2);
            round(mode != 1, mode != 0, rand_addr(), 1'($urandom), 4'($urandom), rand_addr(), $urandom);
        end

        // Sweep every in-range word through the fetch port
        for (int w = 0; w < DEPTH; w++) round(1'b1, 1'b0, 8'(w * 4 + $urandom_range(0, 3)), 1'b0, 4'h0, 8'h0, 32'h0);

        // Zero-wait instance
        w0_op(1'b1, 8'h20, 32'hCAFEF00D, 32'h0);
        w0_op(1'b0, 8'h20, 32'h0, 32'hCAFEF00D);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
